bayer_pattern_gen: RTL

BAYER_PATTERN_GEN -- requirements
Module: bayer_pattern_gen

---
 rtl/bayer_pkg.sv | 47 ++++
 rtl/bayer_timing_ctrl.sv | 137 +++++++++++++
 rtl/bayer_pattern_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/bayer_pkg.sv
// rtl/bayer_pkg.sv - shared types, codes and colour helpers for the Bayer test pattern generator
package bayer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_SOLID   = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_t;

    typedef enum logic [1:0] {
        FMT_RGGB = 2'd0,
        FMT_GRBG = 2'd1,
        FMT_GBRG = 2'd2,
        FMT_BGGR = 2'd3
    } bayer_fmt_t;

    // Index 8 and above is the black region past the last bar.
    function automatic logic [23:0] bar_rgb(input logic [3:0] idx);
        case (idx)
            4'd0:    return 24'hFFFFFF;
            4'd1:    return 24'hFFFF00;
            4'd2:    return 24'h00FFFF;
            4'd3:    return 24'h00FF00;
            4'd4:    return 24'hFF00FF;
            4'd5:    return 24'hFF0000;
            4'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [7:0] bayer_component(input logic [23:0] rgb, input logic [1:0] phase);
        case (phase)
            2'b00:   return rgb[23:16];
            2'b11:   return rgb[7:0];
            default: return rgb[15:8];
        endcase
    endfunction

endpackage

// File: rtl/bayer_timing_ctrl.sv
// rtl/bayer_timing_ctrl.sv - frame timing FSM with x/y/blank counters and frame counter
module bayer_timing_ctrl
    import bayer_pkg::*;
#(
    parameter int G_RES_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic [G_RES_WIDTH-1:0] i_hres,
    input  logic [G_RES_WIDTH-1:0] i_vres,
    input  logic [G_RES_WIDTH-1:0] i_hblank,
    input  logic [G_RES_WIDTH-1:0] i_vblank,
    output logic                   o_load,
    output logic                   o_active,
    output logic                   o_first,
    output logic                   o_last_x,
    output logic [G_RES_WIDTH-1:0] o_x,
    output logic [3:0]             o_y_low,
    output logic [G_RES_WIDTH-1:0] o_bar_w,
    output logic [G_RES_WIDTH-1:0] o_frame_count
);

    state_t                 r_state, w_state_n;
    logic [G_RES_WIDTH-1:0] r_x, r_y, r_cnt, w_x_n, w_y_n, w_cnt_n;
    logic [G_RES_WIDTH-1:0] r_hres, r_vres, r_hblank, r_vblank, r_frame_count;
    logic                   w_cfg_ok, w_last_x, w_last_y, w_line_done, w_frame_done, w_load;

    assign w_cfg_ok = i_en && (i_hres != '0) && (i_vres != '0);
    assign w_last_x = (r_x == r_hres - G_RES_WIDTH'(1));
    assign w_last_y = (r_y == r_vres - G_RES_WIDTH'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_cnt         <= '0;
            r_hres        <= '0;
            r_vres        <= '0;
            r_hblank      <= '0;
            r_vblank      <= '0;
            r_frame_count <= '0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_y     <= w_y_n;
            r_cnt   <= w_cnt_n;
            if (w_load) begin
                r_hres   <= i_hres;
                r_vres   <= i_vres;
                r_hblank <= i_hblank;
                r_vblank <= i_vblank;
            end
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + G_RES_WIDTH'(1);
            end
        end
    end

    // Line and frame completion are resolved after the state case so that
    // zero-length blanking collapses straight through to the next step.
    always_comb begin
        w_state_n    = r_state;
        w_x_n        = r_x;
        w_y_n        = r_y;
        w_cnt_n      = r_cnt;
        w_load       = 1'b0;
        w_line_done  = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_ok) begin
                    w_load    = 1'b1;
                    w_state_n = ST_ACTIVE;
                    w_x_n     = '0;
                    w_y_n     = '0;
                end
            end
            ST_ACTIVE: begin
                if (w_last_x) begin
                    if (r_hblank != '0) begin
                        w_state_n = ST_HBLANK;
                        w_cnt_n   = '0;
                    end else begin
                        w_line_done = 1'b1;
                    end
                end else begin
                    w_x_n = r_x + G_RES_WIDTH'(1);
                end
            end
            ST_HBLANK: begin
                if (r_cnt == r_hblank - G_RES_WIDTH'(1)) w_line_done = 1'b1;
                else                                      w_cnt_n = r_cnt + G_RES_WIDTH'(1);
            end
            ST_VBLANK: begin
                if (r_cnt == r_vblank - G_RES_WIDTH'(1)) w_frame_done = 1'b1;
                else                                      w_cnt_n = r_cnt + G_RES_WIDTH'(1);
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (w_line_done) begin
            w_x_n = '0;
            if (w_last_y) begin
                if (r_vblank != '0) begin
                    w_state_n = ST_VBLANK;
                    w_cnt_n   = '0;
                end else begin
                    w_frame_done = 1'b1;
                end
            end else begin
                w_y_n     = r_y + G_RES_WIDTH'(1);
                w_state_n = ST_ACTIVE;
            end
        end
        if (w_frame_done) begin
            w_x_n = '0;
            w_y_n = '0;
            if (w_cfg_ok) begin
                w_load    = 1'b1;
                w_state_n = ST_ACTIVE;
            end else begin
                w_state_n = ST_IDLE;
            end
        end
    end

    assign o_load        = w_load;
    assign o_active      = (r_state == ST_ACTIVE);
    assign o_first       = o_active && (r_x == '0) && (r_y == '0);
    assign o_last_x      = o_active && w_last_x;
    assign o_x           = r_x;
    assign o_y_low       = r_y[3:0];
    assign o_bar_w       = r_hres >> 3;
    assign o_frame_count = r_frame_count;

endmodule

// File: rtl/bayer_pattern_gen.sv
// rtl/bayer_pattern_gen.sv - raw Bayer test pattern generator top: pattern, mosaic and output registers
module bayer_pattern_gen
    import bayer_pkg::*;
#(
    parameter int G_PIX_WIDTH = 8,
    parameter int G_RES_WIDTH = 16
) (
    input  logic                   SYS_CLK_I,
    input  logic                   RESETN_I,
    input  logic                   EN_I,
    input  logic [G_RES_WIDTH-1:0] hres_i,
    input  logic [G_RES_WIDTH-1:0] vres_i,
    input  logic [G_RES_WIDTH-1:0] hblank_i,
    input  logic [G_RES_WIDTH-1:0] vblank_i,
    input  logic [1:0]             BAYER_FORMAT_I,
    input  logic [1:0]             pattern_sel_i,
    input  logic [23:0]            solid_rgb_i,
    output logic [G_PIX_WIDTH-1:0] DATA_O,
    output logic                   DATA_VALID_O,
    output logic                   frame_start_o,
    output logic                   line_end_o,
    output logic [G_RES_WIDTH-1:0] frame_count_o
);

    logic                   w_load, w_active, w_first, w_last_x;
    logic [G_RES_WIDTH-1:0] w_x, w_bar_w;
    logic [3:0]             w_y_low, w_bar_idx;
    logic [1:0]             r_fmt, w_phase;
    pattern_t               r_pattern;
    logic [23:0]            r_solid, w_rgb;
    logic [7:0]             w_comp;
    logic [G_PIX_WIDTH-1:0] w_pix, r_data;
    logic                   r_valid, r_first, r_last_x;

    bayer_timing_ctrl #(.G_RES_WIDTH(G_RES_WIDTH)) u_timing (
        .i_clk         (SYS_CLK_I),
        .i_rst_n       (RESETN_I),
        .i_en          (EN_I),
        .i_hres        (hres_i),
        .i_vres        (vres_i),
        .i_hblank      (hblank_i),
        .i_vblank      (vblank_i),
        .o_load        (w_load),
        .o_active      (w_active),
        .o_first       (w_first),
        .o_last_x      (w_last_x),
        .o_x           (w_x),
        .o_y_low       (w_y_low),
        .o_bar_w       (w_bar_w),
        .o_frame_count (frame_count_o)
    );

    always_ff @(posedge SYS_CLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            r_fmt     <= '0;
            r_pattern <= PAT_BARS;
            r_solid   <= '0;
        end else if (w_load) begin
            r_fmt     <= BAYER_FORMAT_I;
            r_pattern <= pattern_t'(pattern_sel_i);
            r_solid   <= solid_rgb_i;
        end
    end

    // Bar index by comparison against bar boundaries; a zero bar width leaves every pixel black.
    always_comb begin
        w_bar_idx = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if ({3'b000, w_x} < (G_RES_WIDTH+3)'(i + 1) * {3'b000, w_bar_w}) w_bar_idx = 4'(i);
        end
    end

    always_comb begin
        w_rgb = '0;
        case (r_pattern)
            PAT_BARS:    w_rgb = bar_rgb(w_bar_idx);
            PAT_RAMP:    w_rgb = {3{w_x[7:0]}};
            PAT_SOLID:   w_rgb = r_solid;
            PAT_CHECKER: w_rgb = {24{w_x[3] ^ w_y_low[3]}};
            default:     w_rgb = '0;
        endcase
    end

    assign w_phase = {w_y_low[0] ^ r_fmt[1], w_x[0] ^ r_fmt[0]};
    assign w_comp  = bayer_component(w_rgb, w_phase);

    generate
        if (G_PIX_WIDTH >= 8) begin : g_pix_wide
            assign w_pix = G_PIX_WIDTH'(w_comp) << (G_PIX_WIDTH - 8);
        end else begin : g_pix_narrow
            assign w_pix = w_comp[7 -: G_PIX_WIDTH];
        end
    endgenerate

    always_ff @(posedge SYS_CLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_last_x <= 1'b0;
        end else begin
            r_data   <= w_active ? w_pix : '0;
            r_valid  <= w_active;
            r_first  <= w_first;
            r_last_x <= w_last_x;
        end
    end

    assign DATA_O        = r_data;
    assign DATA_VALID_O  = r_valid;
    assign frame_start_o = r_first;
    assign line_end_o    = r_last_x;

endmodule
